mult_div_unit: RTL



---
 rtl/mult_div_unit.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit for the E stage: computes the result at start and holds busy for a fixed latency.
// Optional MULT_DIV_MADD_EN enables madd/maddu/msub/msubu (md_op 4..7).
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        md_start,
    input  logic [2:0]  md_op,
    input  logic        hl_write,
    input  logic        hl_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MULT = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    logic [1:0]  r_state;
    logic [4:0]  r_count;
    logic        r_busy;
    logic        r_wr_en;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [31:0] r_res_hi;
    logic [31:0] r_res_lo;

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic [31:0] w_den_s;
    logic [31:0] w_den_u;
    logic [31:0] w_uq_s;
    logic [31:0] w_ur_s;
    logic [31:0] w_q_s;
    logic [31:0] w_r_s;
    logic [31:0] w_q_u;
    logic [31:0] w_r_u;
    logic [31:0] w_res_hi;
    logic [31:0] w_res_lo;
    logic        w_op_ok;
    logic        w_is_div;
    logic        w_wr_en;
    logic        w_start;
`ifdef MULT_DIV_MADD_EN
    logic [63:0] w_acc;
    assign w_acc = {r_hi, r_lo};
`endif

    assign w_prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign w_prod_u = {32'd0, a} * {32'd0, b};

    // Signed divide through magnitudes so 0x80000000 / -1 wraps cleanly; zero divisor is steered to 1 and its result discarded.
    assign w_a_neg = a[31];
    assign w_b_neg = b[31];
    assign w_abs_a = w_a_neg ? (~a + 32'd1) : a;
    assign w_abs_b = w_b_neg ? (~b + 32'd1) : b;
    assign w_den_s = (w_abs_b == 32'd0) ? 32'd1 : w_abs_b;
    assign w_den_u = (b == 32'd0) ? 32'd1 : b;
    assign w_uq_s  = w_abs_a / w_den_s;
    assign w_ur_s  = w_abs_a % w_den_s;
    assign w_q_s   = (w_a_neg ^ w_b_neg) ? (~w_uq_s + 32'd1) : w_uq_s;
    assign w_r_s   = w_a_neg ? (~w_ur_s + 32'd1) : w_ur_s;
    assign w_q_u   = a / w_den_u;
    assign w_r_u   = a % w_den_u;

    // Decode the requested operation into a pending result and its write enable.
    always_comb begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
        w_op_ok  = 1'b1;
        w_is_div = 1'b0;
        w_wr_en  = 1'b1;
        case (md_op)
            3'd0: {w_res_hi, w_res_lo} = w_prod_s;
            3'd1: {w_res_hi, w_res_lo} = w_prod_u;
            3'd2: begin
                w_is_div = 1'b1;
                w_wr_en  = (b != 32'd0);
                w_res_hi = w_r_s;
                w_res_lo = w_q_s;
            end
            3'd3: begin
                w_is_div = 1'b1;
                w_wr_en  = (b != 32'd0);
                w_res_hi = w_r_u;
                w_res_lo = w_q_u;
            end
`ifdef MULT_DIV_MADD_EN
            3'd4: {w_res_hi, w_res_lo} = w_acc + w_prod_s;
            3'd5: {w_res_hi, w_res_lo} = w_acc + w_prod_u;
            3'd6: {w_res_hi, w_res_lo} = w_acc - w_prod_s;
            3'd7: {w_res_hi, w_res_lo} = w_acc - w_prod_u;
`endif
            default: begin
                w_op_ok = 1'b0;
                w_wr_en = 1'b0;
            end
        endcase
    end

    assign w_start = md_start && w_op_ok && (r_state == S_IDLE);

    // Sequencer: hold busy for the op latency, then commit the pending result.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_count  <= 5'd0;
            r_busy   <= 1'b0;
            r_wr_en  <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_res_hi <= 32'd0;
            r_res_lo <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_res_hi <= w_res_hi;
                        r_res_lo <= w_res_lo;
                        r_wr_en  <= w_wr_en;
                        r_busy   <= 1'b1;
                        r_count  <= w_is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                        r_state  <= w_is_div ? S_DIV : S_MULT;
                    end else if (hl_write && !md_start) begin
                        if (hl_sel) begin
                            r_hi <= a;
                        end else begin
                            r_lo <= a;
                        end
                    end
                end
                S_MULT, S_DIV: begin
                    if (r_count == 5'd1) begin
                        if (r_wr_en) begin
                            r_hi <= r_res_hi;
                            r_lo <= r_res_lo;
                        end
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    r_count <= r_count - 5'd1;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_count <= 5'd0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
